// File: rtl/sincpde_dfs_core_if.sv
// Bus between the SINCPDE sequencer and its attached divider and IMAC cores.
// The sequencer connects through the master modport and the cores through the slave modport.
interface sincpde_dfs_core_if;
    logic signed [47:0] DIV_0_N;
    logic signed [47:0] DIV_0_D;
    logic signed [17:0] DIV_0_Q;
    logic               DIV_0_sync_in;
    logic               DIV_0_sync_out;
    logic        [1:0]  IMAC_0_MODE;
    logic signed [17:0] IMAC_0_S0;
    logic signed [17:0] IMAC_0_S1;
    logic signed [17:0] IMAC_0_S2;
    logic signed [17:0] IMAC_0_S3;
    logic signed [17:0] IMAC_0_S4;
    logic signed [17:0] IMAC_0_S5;
    logic signed [17:0] IMAC_0_S6;
    logic signed [17:0] IMAC_0_S7;
    logic signed [17:0] IMAC_0_S8;
    logic signed [17:0] IMAC_0_S9;
    logic signed [17:0] IMAC_0_S10;
    logic signed [17:0] IMAC_0_X;
    logic signed [47:0] IMAC_0_Y;
    logic signed [47:0] IMAC_0_Z;
    logic               IMAC_0_sync_in;
    logic               IMAC_0_sync_out;

    modport master (
        output DIV_0_N, DIV_0_D, DIV_0_sync_in, DIV_0_sync_out,
        output IMAC_0_MODE, IMAC_0_X, IMAC_0_Y, IMAC_0_sync_in, IMAC_0_sync_out,
        output IMAC_0_S0, IMAC_0_S1, IMAC_0_S2, IMAC_0_S3, IMAC_0_S4, IMAC_0_S5,
        output IMAC_0_S6, IMAC_0_S7, IMAC_0_S8, IMAC_0_S9, IMAC_0_S10,
        input  DIV_0_Q, IMAC_0_Z
    );

    modport slave (
        input  DIV_0_N, DIV_0_D, DIV_0_sync_in, DIV_0_sync_out,
        input  IMAC_0_MODE, IMAC_0_X, IMAC_0_Y, IMAC_0_sync_in, IMAC_0_sync_out,
        input  IMAC_0_S0, IMAC_0_S1, IMAC_0_S2, IMAC_0_S3, IMAC_0_S4, IMAC_0_S5,
        input  IMAC_0_S6, IMAC_0_S7, IMAC_0_S8, IMAC_0_S9, IMAC_0_S10,
        output DIV_0_Q, IMAC_0_Z
    );
endinterface

// File: rtl/sincpde_dfs_core.sv
// SINCPDE sequencer: 7 divides then 6 IMAC ops, results captured at predicted cycles and streamed on out.
// Optional SYNC_IN_START_EN: start on sync_in and rearm after DONE; otherwise auto-start after reset.
module sincpde_dfs_core #(
    parameter int DIV_LAT  = 20,
    parameter int IMAC_LAT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sync_in,
    output logic               sync_out,
    output logic signed [47:0] out,
    sincpde_dfs_core_if.master core
);

    typedef enum logic [2:0] {
        IDLE, DIV_ISSUE, DIV_WAIT, IMAC_ISSUE, IMAC_WAIT, STREAM, DONE
    } state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic [DIV_LAT-1:0]  dsr_q, dsr_d;
    logic [IMAC_LAT-1:0] isr_q, isr_d;

    logic       dcap_on_q, dcap_on_d;
    logic [2:0] dcap_idx_q, dcap_idx_d;
    logic       icap_on_q, icap_on_d;
    logic [2:0] icap_idx_q, icap_idx_d;

    logic signed [47:0] dbuf_q [7];
    logic signed [47:0] dbuf_d [7];
    logic signed [47:0] ibuf_q [6];
    logic signed [47:0] ibuf_d [6];

    logic               sync_out_q, sync_out_d;
    logic signed [47:0] out_q, out_d;
    logic signed [47:0] div_num_q, div_num_d;
    logic signed [47:0] div_den_q, div_den_d;
    logic               div_si_q, div_si_d;
    logic        [1:0]  imac_mode_q, imac_mode_d;
    logic signed [17:0] imac_x_q, imac_x_d;
    logic signed [47:0] imac_y_q, imac_y_d;
    logic               imac_si_q, imac_si_d;
    logic signed [17:0] s_q [11];
    logic signed [17:0] s_d [11];

    logic start;
    logic div_res, imac_res;
    logic dcap_last, icap_last;
    logic [3:0] ioff;

`ifdef SYNC_IN_START_EN
    assign start = sync_in;
`else
    logic unused_sync_in;
    assign start          = 1'b1;
    assign unused_sync_in = sync_in;
`endif

    // Predicted result pulses: the issue pulse delayed by the core latency.
    assign div_res  = dsr_q[DIV_LAT-1];
    assign imac_res = isr_q[IMAC_LAT-1];

    always_comb begin
        dsr_d = DIV_LAT'({dsr_q, div_si_q});
        isr_d = IMAC_LAT'({isr_q, imac_si_q});
        for (int unsigned k = 0; k < 11; k++) begin
            s_d[k] = 18'(k + 3);
        end
    end

    assign dcap_last = dcap_on_q && (dcap_idx_q == 3'd6);
    assign icap_last = icap_on_q && (icap_idx_q == 3'd5);

    // Capture windows open on the predicted pulse and run for the rest of the burst.
    always_comb begin
        dbuf_d     = dbuf_q;
        dcap_on_d  = dcap_on_q;
        dcap_idx_d = dcap_idx_q;
        if (div_res) begin
            dbuf_d[0]  = {{30{core.DIV_0_Q[17]}}, core.DIV_0_Q};
            dcap_on_d  = 1'b1;
            dcap_idx_d = 3'd1;
        end else if (dcap_on_q) begin
            dbuf_d[dcap_idx_q] = {{30{core.DIV_0_Q[17]}}, core.DIV_0_Q};
            dcap_idx_d         = dcap_idx_q + 3'd1;
            if (dcap_idx_q == 3'd6) begin
                dcap_on_d  = 1'b0;
                dcap_idx_d = '0;
            end
        end
    end

    always_comb begin
        ibuf_d     = ibuf_q;
        icap_on_d  = icap_on_q;
        icap_idx_d = icap_idx_q;
        if (imac_res) begin
            ibuf_d[0]  = core.IMAC_0_Z;
            icap_on_d  = 1'b1;
            icap_idx_d = 3'd1;
        end else if (icap_on_q) begin
            ibuf_d[icap_idx_q] = core.IMAC_0_Z;
            icap_idx_d         = icap_idx_q + 3'd1;
            if (icap_idx_q == 3'd5) begin
                icap_on_d  = 1'b0;
                icap_idx_d = '0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DIV_ISSUE;
                    cnt_d   = '0;
                end
            end
            DIV_ISSUE: begin
                if (cnt_q == 4'd6) begin
                    state_d = DIV_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DIV_WAIT: begin
                if (dcap_last) begin
                    state_d = IMAC_ISSUE;
                    cnt_d   = '0;
                end
            end
            IMAC_ISSUE: begin
                if (cnt_q == 4'd5) begin
                    state_d = IMAC_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            IMAC_WAIT: begin
                if (icap_last) begin
                    state_d = STREAM;
                    cnt_d   = '0;
                end
            end
            STREAM: begin
                if (cnt_q == 4'd12) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
`ifdef SYNC_IN_START_EN
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        div_si_d    = 1'b0;
        div_num_d   = '0;
        div_den_d   = '0;
        imac_si_d   = 1'b0;
        imac_mode_d = '0;
        imac_x_d    = '0;
        imac_y_d    = '0;
        sync_out_d  = 1'b0;
        out_d       = '0;
        ioff        = cnt_d - 4'd7;
        if (state_d == DIV_ISSUE) begin
            div_si_d = (cnt_d == 4'd0);
            case (cnt_d)
                4'd0: begin div_num_d = 48'sd100;     div_den_d = 48'sd7;  end
                4'd1: begin div_num_d = -48'sd100;    div_den_d = 48'sd7;  end
                4'd2: begin div_num_d = 48'sd1000000; div_den_d = 48'sd3;  end
                4'd3: begin div_num_d = 48'sd5;       div_den_d = 48'sd0;  end
                4'd4: begin div_num_d = 48'sd0;       div_den_d = 48'sd9;  end
                4'd5: begin div_num_d = -48'sd5;      div_den_d = 48'sd0;  end
                4'd6: begin div_num_d = 48'sd42;      div_den_d = -48'sd6; end
                default: ;
            endcase
        end
        if (state_d == IMAC_ISSUE) begin
            imac_si_d = (cnt_d == 4'd0);
            case (cnt_d)
                4'd0: begin imac_x_d = 18'sd10;     imac_y_d = 48'sd1000; imac_mode_d = 2'd1; end
                4'd1: begin imac_x_d = 18'sd10;     imac_y_d = 48'sd1000; imac_mode_d = 2'd2; end
                4'd2: begin imac_x_d = -18'sd4;     imac_y_d = 48'sd0;    imac_mode_d = 2'd3; end
                4'd3: begin imac_x_d = 18'sd0;      imac_y_d = -48'sd5;   imac_mode_d = 2'd0; end
                4'd4: begin imac_x_d = 18'sd131071; imac_y_d = 48'sd0;    imac_mode_d = 2'd3; end
                4'd5: begin imac_x_d = 18'sd7;      imac_y_d = 48'sd7;    imac_mode_d = 2'd1; end
                default: ;
            endcase
        end
        if (state_d == STREAM) begin
            sync_out_d = (cnt_d == 4'd0);
            out_d      = (cnt_d < 4'd7) ? dbuf_q[cnt_d[2:0]] : ibuf_q[ioff[2:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dsr_q       <= '0;
            isr_q       <= '0;
            dcap_on_q   <= 1'b0;
            dcap_idx_q  <= '0;
            icap_on_q   <= 1'b0;
            icap_idx_q  <= '0;
            dbuf_q      <= '{default: '0};
            ibuf_q      <= '{default: '0};
            sync_out_q  <= 1'b0;
            out_q       <= '0;
            div_num_q   <= '0;
            div_den_q   <= '0;
            div_si_q    <= 1'b0;
            imac_mode_q <= '0;
            imac_x_q    <= '0;
            imac_y_q    <= '0;
            imac_si_q   <= 1'b0;
            s_q         <= '{default: '0};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dsr_q       <= dsr_d;
            isr_q       <= isr_d;
            dcap_on_q   <= dcap_on_d;
            dcap_idx_q  <= dcap_idx_d;
            icap_on_q   <= icap_on_d;
            icap_idx_q  <= icap_idx_d;
            dbuf_q      <= dbuf_d;
            ibuf_q      <= ibuf_d;
            sync_out_q  <= sync_out_d;
            out_q       <= out_d;
            div_num_q   <= div_num_d;
            div_den_q   <= div_den_d;
            div_si_q    <= div_si_d;
            imac_mode_q <= imac_mode_d;
            imac_x_q    <= imac_x_d;
            imac_y_q    <= imac_y_d;
            imac_si_q   <= imac_si_d;
            s_q         <= s_d;
        end
    end

    assign sync_out             = sync_out_q;
    assign out                  = out_q;
    assign core.DIV_0_N         = div_num_q;
    assign core.DIV_0_D         = div_den_q;
    assign core.DIV_0_sync_in   = div_si_q;
    assign core.DIV_0_sync_out  = div_res;
    assign core.IMAC_0_MODE     = imac_mode_q;
    assign core.IMAC_0_X        = imac_x_q;
    assign core.IMAC_0_Y        = imac_y_q;
    assign core.IMAC_0_sync_in  = imac_si_q;
    assign core.IMAC_0_sync_out = imac_res;
    assign core.IMAC_0_S0       = s_q[0];
    assign core.IMAC_0_S1       = s_q[1];
    assign core.IMAC_0_S2       = s_q[2];
    assign core.IMAC_0_S3       = s_q[3];
    assign core.IMAC_0_S4       = s_q[4];
    assign core.IMAC_0_S5       = s_q[5];
    assign core.IMAC_0_S6       = s_q[6];
    assign core.IMAC_0_S7       = s_q[7];
    assign core.IMAC_0_S8       = s_q[8];
    assign core.IMAC_0_S9       = s_q[9];
    assign core.IMAC_0_S10      = s_q[10];

endmodule

// File: tb/tb_sincpde_dfs_core.sv
// Bench for sincpde_dfs_core: two instances (DIV_LAT/IMAC_LAT = 20/4 and 5/1) with behavioural cores,
// checked every cycle against a timeline model of the program; honours SYNC_IN_START_EN.
module tb_sincpde_dfs_core;
    localparam int NI = 2;
`ifdef SYNC_IN_START_EN
    localparam bit SYNC_MODE = 1'b1;
    localparam int NSTREAM   = 3;
`else
    localparam bit SYNC_MODE = 1'b0;
    localparam int NSTREAM   = 2;
`endif

    typedef struct packed {
        logic               sync_out;
        logic signed [47:0] out;
        logic signed [47:0] n;
        logic signed [47:0] d;
        logic               dsi;
        logic               dso;
        logic [1:0]         mode;
        logic [10:0][17:0]  s;
        logic signed [17:0] x;
        logic signed [47:0] y;
        logic               isi;
        logic               iso;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sync_in = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int     dl_of [NI] = '{20, 5};
    int     il_of [NI] = '{4, 1};
    longint tn [7] = '{100, -100, 1000000, 5, 0, -5, 42};
    longint td [7] = '{7, 7, 3, 0, 9, 0, -6};
    longint tx [6] = '{10, 10, -4, 0, 131071, 7};
    longint ty [6] = '{1000, 1000, 0, -5, 0, 7};
    longint tm [6] = '{1, 2, 3, 0, 3, 1};
    longint lit [13] = '{14, -14, 131071, 131071, 0, -131072, -7, 1030, 970, -12, -5, 393213, 28};
    longint exp_stream [13];

    logic m_seen = 1'b0;
    logic m_lastrst = 1'b0;
    logic m_idle [NI] = '{1'b1, 1'b1};
    logic m_run  [NI] = '{1'b0, 1'b0};
    int   t0     [NI] = '{0, 0};
    int   npulse [NI] = '{0, 0};

    function automatic logic signed [17:0] div_ref(input longint n, input longint d);
        longint q;
        if (d == 0) return (n >= 0) ? 18'(131071) : 18'(-131072);
        q = n / d;
        if (q > 131071) q = 131071;
        else if (q < -131072) q = -131072;
        return 18'(q);
    endfunction

    function automatic logic signed [47:0] imac_ref(input longint mode, input longint x,
                                                    input longint y, input longint s0);
        case (mode)
            0: return 48'(y);
            1: return 48'(y + x * s0);
            2: return 48'(y - x * s0);
            default: return 48'(x * s0);
        endcase
    endfunction

    for (genvar g = 0; g < NI; g++) begin : gi
        localparam int DL = (g == 0) ? 20 : 5;
        localparam int IL = (g == 0) ? 4 : 1;
        sincpde_dfs_core_if bus ();
        logic               so;
        logic signed [47:0] o;
        obs_t               obs;

        sincpde_dfs_core #(.DIV_LAT(DL), .IMAC_LAT(IL)) dut (
            .clk(clk), .rst(rst), .sync_in(sync_in), .sync_out(so), .out(o), .core(bus)
        );

        // Behavioural cores: result appears exactly DL / IL cycles after the operands.
        logic signed [47:0] hn [DL];
        logic signed [47:0] hd [DL];
        logic signed [17:0] hx [IL];
        logic signed [47:0] hy [IL];
        logic        [1:0]  hm [IL];
        always @(posedge clk) begin
            hn[0] <= bus.DIV_0_N;
            hd[0] <= bus.DIV_0_D;
            for (int k = 1; k < DL; k++) begin
                hn[k] <= hn[k-1];
                hd[k] <= hd[k-1];
            end
            hx[0] <= bus.IMAC_0_X;
            hy[0] <= bus.IMAC_0_Y;
            hm[0] <= bus.IMAC_0_MODE;
            for (int k = 1; k < IL; k++) begin
                hx[k] <= hx[k-1];
                hy[k] <= hy[k-1];
                hm[k] <= hm[k-1];
            end
        end
        assign bus.DIV_0_Q  = div_ref(hn[DL-1], hd[DL-1]);
        assign bus.IMAC_0_Z = imac_ref(longint'(hm[IL-1]), hx[IL-1], hy[IL-1], bus.IMAC_0_S0);

        assign obs = {so, o, bus.DIV_0_N, bus.DIV_0_D, bus.DIV_0_sync_in, bus.DIV_0_sync_out,
                      bus.IMAC_0_MODE,
                      bus.IMAC_0_S10, bus.IMAC_0_S9, bus.IMAC_0_S8, bus.IMAC_0_S7, bus.IMAC_0_S6,
                      bus.IMAC_0_S5, bus.IMAC_0_S4, bus.IMAC_0_S3, bus.IMAC_0_S2, bus.IMAC_0_S1,
                      bus.IMAC_0_S0,
                      bus.IMAC_0_X, bus.IMAC_0_Y, bus.IMAC_0_sync_in, bus.IMAC_0_sync_out};
    end

    // Program timeline model: t0 is the cycle carrying DIV_0_sync_in.
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        m_lastrst <= rst;
        if (rst) m_seen <= 1'b1;
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                m_idle[i] <= 1'b1;
                m_run[i]  <= 1'b0;
            end else if (m_idle[i]) begin
                if (!SYNC_MODE || sync_in) begin
                    t0[i]     <= cyc + 1;
                    m_run[i]  <= 1'b1;
                    m_idle[i] <= 1'b0;
                end
            end else if (SYNC_MODE && m_run[i] &&
                         (cyc + 1 - t0[i] == dl_of[i] + il_of[i] + 13 + 14)) begin
                m_idle[i] <= 1'b1;
                m_run[i]  <= 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input int i, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s u%0d cyc=%0d got=%0d want=%0d", nm, i, cyc, act, exp);
        end
    endtask

    task automatic check_inst(input int i, input obs_t ob);
        int     d, t1, t2;
        longint e_n, e_d, e_x, e_y, e_m, e_out;
        longint e_dsi, e_dso, e_isi, e_iso, e_so;
        d  = cyc - t0[i];
        t1 = dl_of[i] + 7;
        t2 = t1 + il_of[i] + 6;
        e_n = 0; e_d = 0; e_x = 0; e_y = 0; e_m = 0; e_out = 0;
        e_dsi = 0; e_dso = 0; e_isi = 0; e_iso = 0; e_so = 0;
        if (m_run[i]) begin
            if (d >= 0 && d < 7) begin e_n = tn[d]; e_d = td[d]; end
            if (d >= t1 && d < t1 + 6) begin
                e_x = tx[d-t1]; e_y = ty[d-t1]; e_m = tm[d-t1];
            end
            if (d >= t2 && d < t2 + 13) e_out = exp_stream[d-t2];
            e_dsi = (d == 0) ? 1 : 0;
            e_dso = (d == dl_of[i]) ? 1 : 0;
            e_isi = (d == t1) ? 1 : 0;
            e_iso = (d == t1 + il_of[i]) ? 1 : 0;
            e_so  = (d == t2) ? 1 : 0;
        end
        chk("DIV_0_N", i, ob.n, e_n);
        chk("DIV_0_D", i, ob.d, e_d);
        chk("DIV_0_sync_in", i, longint'(ob.dsi), e_dsi);
        chk("DIV_0_sync_out", i, longint'(ob.dso), e_dso);
        chk("IMAC_0_X", i, ob.x, e_x);
        chk("IMAC_0_Y", i, ob.y, e_y);
        chk("IMAC_0_MODE", i, longint'(ob.mode), e_m);
        chk("IMAC_0_sync_in", i, longint'(ob.isi), e_isi);
        chk("IMAC_0_sync_out", i, longint'(ob.iso), e_iso);
        chk("sync_out", i, longint'(ob.sync_out), e_so);
        chk("out", i, ob.out, e_out);
        if (m_run[i] && d >= t2 && d < t2 + 13) chk("out_literal", i, ob.out, lit[d-t2]);
        for (int k = 0; k < 11; k++) begin
            chk("IMAC_0_S", i, longint'(ob.s[k]), m_lastrst ? 0 : longint'(k + 3));
        end
        if (ob.sync_out) npulse[i]++;
    endtask

    always @(negedge clk) begin
        if (m_seen) begin
            check_inst(0, gi[0].obs);
            check_inst(1, gi[1].obs);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (!SYNC_MODE) sync_in = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        if (SYNC_MODE) begin
            sync_in = 1'b1;
            step();
            sync_in = 1'b0;
        end
    endtask

    initial begin
        for (int k = 0; k < 7; k++) exp_stream[k] = div_ref(tn[k], td[k]);
        for (int k = 0; k < 6; k++) exp_stream[7+k] = imac_ref(tm[k], tx[k], ty[k], 3);

        do_reset(5);
        if (SYNC_MODE) begin
            repeat (10) step();
            pulse_start();
            repeat (4) step();
            sync_in = 1'b1;
            step();
            sync_in = 1'b0;
        end
        repeat (90) step();

        do_reset(2);
        pulse_start();
        repeat (8 + $urandom_range(0, 10)) step();
        do_reset(1 + $urandom_range(0, 2));

        pulse_start();
        repeat (90) step();

        if (SYNC_MODE) begin
            pulse_start();
            repeat (90) step();
        end

        @(negedge clk);
        #1;
        for (int i = 0; i < NI; i++) chk("stream_count", i, npulse[i], NSTREAM);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
